// File: rtl/USBPkg.sv
// Shared definitions for the USB transaction sequencer.
// Holds the handshake/data PID encodings, endpoint numbers, bus widths
// and the sequencer state encoding used by txn_sequencer.
package USBPkg;

    localparam int unsigned PAGE_W  = 16;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ENDP_W  = 4;
    localparam int unsigned PID_W   = 4;
    localparam int unsigned STATE_W = 4;

    // Received packet identifiers
    localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
    localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;
    localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;

    // Device endpoints: address setup and data transfer
    localparam logic [ENDP_W-1:0] ENDP_ADDR = 4'd4;
    localparam logic [ENDP_W-1:0] ENDP_DATA = 4'd8;

    typedef logic [STATE_W-1:0] seq_state_t;

    localparam seq_state_t S_IDLE      = 4'd0;
    localparam seq_state_t S_ADDR_OUT  = 4'd1;
    localparam seq_state_t S_ADDR_DATA = 4'd2;
    localparam seq_state_t S_ADDR_HS   = 4'd3;
    localparam seq_state_t S_XFER_OUT  = 4'd4;
    localparam seq_state_t S_XFER_DATA = 4'd5;
    localparam seq_state_t S_XFER_HS   = 4'd6;
    localparam seq_state_t S_XFER_IN   = 4'd7;
    localparam seq_state_t S_IN_WAIT   = 4'd8;
    localparam seq_state_t S_SEND_ACK  = 4'd9;
    localparam seq_state_t S_SEND_NAK  = 4'd10;
    localparam seq_state_t S_FINISH    = 4'd11;

    // Address-phase DATA0 payload: page in the top bits, rest zero
    function automatic logic [DATA_W-1:0] addr_payload(input logic [PAGE_W-1:0] page);
        return {page, {(DATA_W - PAGE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/usb_timeout.sv
// Response timeout counter.
// Ports: clock, reset_n (async active-low); clear restarts the count;
// enable advances it; expired is registered and stays high once the
// count reaches TIMEOUT_CYCLES until the next clear.
module usb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_expired;

    // Count enabled cycles; expired rises in the cycle the count equals TIMEOUT_CYCLES
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (clear) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (enable && !r_expired) begin
            r_count   <= r_count + CNT_W'(1);
            r_expired <= (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/txn_sequencer.sv
// USB-style transaction sequencer.
// Runs an address phase (OUT to endpoint 4 + DATA0 page) then either a
// write phase (OUT/DATA0 to endpoint 8) or a read phase (IN to endpoint 8,
// ACK/NAK the returned DATA0), retrying each phase up to MAX_RETRY times.
// Ports: start_read/start_write/mempage/wr_data start a transaction;
// busy/done/success/rd_data report it; send_* / endp / data drive the
// packet sender, out_done acknowledges each packet; rx_* carry the
// decoded device response.
module txn_sequencer
    import USBPkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_read,
    input  logic              start_write,
    input  logic [PAGE_W-1:0] mempage,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [DATA_W-1:0] rd_data,
    output logic              send_OUT,
    output logic              send_IN,
    output logic              send_DATA0,
    output logic              send_ACK,
    output logic              send_NAK,
    output logic [ENDP_W-1:0] endp,
    output logic [DATA_W-1:0] data,
    input  logic              out_done,
    input  logic              rx_valid,
    input  logic [PID_W-1:0]  rx_pid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_error
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    seq_state_t         r_state;
    logic [PAGE_W-1:0]  r_page;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_is_read;
    logic [RETRY_W-1:0] r_retry;
    logic               r_busy;
    logic               r_done;
    logic               r_success;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_send_out;
    logic               r_send_in;
    logic               r_send_data0;
    logic               r_send_ack;
    logic               r_send_nak;
    logic [ENDP_W-1:0]  r_endp;
    logic [DATA_W-1:0]  r_data;

    seq_state_t         w_next;
    logic               w_start;
    logic               w_enter;
    logic               w_retry_inc;
    logic               w_retry_clr;
    logic               w_latch_rd;
    logic               w_to_enable;
    logic               w_expired;
    logic [RETRY_W-1:0] w_retry_next;
    logic               w_retry_limit;

    usb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (out_done),
        .enable  (w_to_enable),
        .expired (w_expired)
    );

    assign w_retry_next  = r_retry + RETRY_W'(1);
    assign w_retry_limit = (w_retry_next == RETRY_W'(MAX_RETRY));
    assign w_enter       = (w_next != r_state);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_latch_rd  = 1'b0;
        w_to_enable = 1'b0;

        case (r_state)
            S_IDLE, S_FINISH: begin
                w_next = S_IDLE;
                if (start_read || start_write) begin
                    w_start = 1'b1;
                    w_next  = S_ADDR_OUT;
                end
            end
            S_ADDR_OUT:  if (out_done) w_next = S_ADDR_DATA;
            S_ADDR_DATA: if (out_done) w_next = S_ADDR_HS;
            S_ADDR_HS: begin
                w_to_enable = 1'b1;
                if (rx_valid) begin
                    if (!rx_error && rx_pid == PID_ACK) begin
                        w_retry_clr = 1'b1;
                        w_next      = r_is_read ? S_XFER_IN : S_XFER_OUT;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_next      = S_ADDR_OUT;
                    end
                end else if (w_expired) begin
                    w_retry_inc = 1'b1;
                    w_next      = S_ADDR_OUT;
                end
            end
            S_XFER_OUT:  if (out_done) w_next = S_XFER_DATA;
            S_XFER_DATA: if (out_done) w_next = S_XFER_HS;
            S_XFER_HS: begin
                w_to_enable = 1'b1;
                if (rx_valid) begin
                    if (!rx_error && rx_pid == PID_ACK) begin
                        w_next = S_FINISH;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_next      = S_XFER_OUT;
                    end
                end else if (w_expired) begin
                    w_retry_inc = 1'b1;
                    w_next      = S_XFER_OUT;
                end
            end
            S_XFER_IN: if (out_done) w_next = S_IN_WAIT;
            S_IN_WAIT: begin
                w_to_enable = 1'b1;
                // Clean non-DATA0 packets are dropped; the wait carries on
                if (rx_valid) begin
                    if (rx_error) begin
                        w_next = S_SEND_NAK;
                    end else if (rx_pid == PID_DATA0) begin
                        w_latch_rd = 1'b1;
                        w_next     = S_SEND_ACK;
                    end
                end else if (w_expired) begin
                    w_retry_inc = 1'b1;
                    w_next      = S_XFER_IN;
                end
            end
            S_SEND_ACK: if (out_done) w_next = S_FINISH;
            S_SEND_NAK: begin
                if (out_done) begin
                    w_retry_inc = 1'b1;
                    w_next      = S_XFER_IN;
                end
            end
            default: w_next = S_IDLE;
        endcase

        // The attempt that exhausts the retry budget ends the transaction
        if (w_retry_inc && w_retry_limit) begin
            w_next = S_FINISH;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_page       <= '0;
            r_wdata      <= '0;
            r_is_read    <= 1'b0;
            r_retry      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_success    <= 1'b0;
            r_rd_data    <= '0;
            r_send_out   <= 1'b0;
            r_send_in    <= 1'b0;
            r_send_data0 <= 1'b0;
            r_send_ack   <= 1'b0;
            r_send_nak   <= 1'b0;
            r_endp       <= '0;
            r_data       <= '0;
        end else begin
            r_busy <= (w_next != S_IDLE) && (w_next != S_FINISH);
            r_done <= (w_next == S_FINISH);

            // Each packet is requested exactly once, on entry to its send state
            r_send_out   <= w_enter && (w_next == S_ADDR_OUT || w_next == S_XFER_OUT);
            r_send_data0 <= w_enter && (w_next == S_ADDR_DATA || w_next == S_XFER_DATA);
            r_send_in    <= w_enter && (w_next == S_XFER_IN);
            r_send_ack   <= w_enter && (w_next == S_SEND_ACK);
            r_send_nak   <= w_enter && (w_next == S_SEND_NAK);

            if (w_start) begin
                r_page    <= mempage;
                r_wdata   <= wr_data;
                r_is_read <= start_read;
                r_success <= 1'b0;
            end

            if (w_start || w_retry_clr) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= w_retry_next;
            end

            // Only an exhausted retry budget reaches FINISH while incrementing
            if (w_enter && w_next == S_FINISH) begin
                r_success <= !w_retry_inc;
            end

            if (w_latch_rd) begin
                r_rd_data <= rx_data;
            end

            // endp/data change only on entry to a send state, so they hold until out_done
            if (w_enter) begin
                case (w_next)
                    S_ADDR_OUT:             r_endp <= ENDP_ADDR;
                    S_XFER_OUT, S_XFER_IN:  r_endp <= ENDP_DATA;
                    S_ADDR_DATA:            r_data <= addr_payload(r_page);
                    S_XFER_DATA:            r_data <= r_wdata;
                    default:                ;
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign success    = r_success;
    assign rd_data    = r_rd_data;
    assign send_OUT   = r_send_out;
    assign send_IN    = r_send_in;
    assign send_DATA0 = r_send_data0;
    assign send_ACK   = r_send_ack;
    assign send_NAK   = r_send_nak;
    assign endp       = r_endp;
    assign data       = r_data;

endmodule

// File: tb/tb_txn_sequencer.sv
// Bench for txn_sequencer: a reactive sender/device responder plus a
// transaction-level reference model that predicts the packet list and result.
module tb_txn_sequencer;
    import USBPkg::*;

    localparam int unsigned TO = 30;
    localparam int unsigned MR = 8;

    localparam int K_OUT = 0, K_IN = 1, K_D0 = 2, K_ACK = 3, K_NAK = 4;
    localparam int R_NONE = 0, R_ACK = 1, R_NAK = 2, R_ERR = 3, R_OTHER = 4, R_DATA = 5, R_DERR = 6;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_read = 1'b0;
    logic        start_write = 1'b0;
    logic [15:0] mempage = '0;
    logic [63:0] wr_data = '0;
    logic        busy, done, success;
    logic [63:0] rd_data;
    logic        send_OUT, send_IN, send_DATA0, send_ACK, send_NAK;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        out_done = 1'b0;
    logic        rx_valid = 1'b0;
    logic [3:0]  rx_pid = '0;
    logic [63:0] rx_data = '0;
    logic        rx_error = 1'b0;

    always #5 clock = ~clock;

    txn_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clock(clock), .reset_n(reset_n),
        .start_read(start_read), .start_write(start_write),
        .mempage(mempage), .wr_data(wr_data),
        .busy(busy), .done(done), .success(success), .rd_data(rd_data),
        .send_OUT(send_OUT), .send_IN(send_IN), .send_DATA0(send_DATA0),
        .send_ACK(send_ACK), .send_NAK(send_NAK),
        .endp(endp), .data(data), .out_done(out_done),
        .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data), .rx_error(rx_error)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int viol = 0;
    bit to_pending = 1'b0;
    int to_ref = 0;

    int          resp_q[$];
    logic [63:0] resp_d_q[$];
    int          scr_q[$];
    logic [63:0] scr_d_q[$];
    int          exp_k[$];
    logic [3:0]  exp_e[$];
    logic [63:0] exp_d[$];
    int          log_k[$];
    logic [3:0]  log_e[$];
    logic [63:0] log_d[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Sender and device: acknowledges every packet, answers DATA0/IN with the scripted response
    initial begin : responder
        int od_t, rx_t, last_k, r, n, k;
        logic [3:0]  h_e;
        logic [63:0] h_d, r_d;
        bit in_fl;
        od_t = 0; rx_t = 0; last_k = 0; r = 0; n = 0; k = 0;
        h_e = '0; h_d = '0; r_d = '0; in_fl = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            out_done = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_pid = 4'h0; rx_data = 64'h0;
            if (!reset_n) begin
                od_t = 0; rx_t = 0; in_fl = 1'b0; to_pending = 1'b0;
                resp_q.delete(); resp_d_q.delete();
                continue;
            end
            if (rx_t > 0) begin
                rx_t--;
                if (rx_t == 0) begin
                    rx_valid = 1'b1;
                    rx_data  = r_d;
                    case (r)
                        R_ACK:   rx_pid = PID_ACK;
                        R_NAK:   rx_pid = PID_NAK;
                        R_ERR:   begin rx_pid = PID_ACK; rx_error = 1'b1; end
                        R_OTHER: rx_pid = PID_DATA0;
                        R_DATA:  rx_pid = PID_DATA0;
                        R_DERR:  begin rx_pid = PID_DATA0; rx_error = 1'b1; end
                        default: rx_valid = 1'b0;
                    endcase
                end
            end
            n = int'(send_OUT) + int'(send_IN) + int'(send_DATA0) + int'(send_ACK) + int'(send_NAK);
            if (n > 1) viol++;
            if (n != 0) begin
                if (in_fl) viol++;
                k = send_OUT ? K_OUT : send_IN ? K_IN : send_DATA0 ? K_D0 : send_ACK ? K_ACK : K_NAK;
                log_k.push_back(k); log_e.push_back(endp); log_d.push_back(data);
                if (to_pending) begin
                    chk("timeout_gap", 64'(cyc - to_ref), 64'(TO + 2));
                    to_pending = 1'b0;
                end
                in_fl = 1'b1; h_e = endp; h_d = data; last_k = k;
                od_t = int'($urandom_range(3, 1));
            end else if (in_fl) begin
                if (endp !== h_e || data !== h_d) viol++;
                od_t--;
                if (od_t == 0) begin
                    out_done = 1'b1;
                    in_fl = 1'b0;
                    if (last_k == K_D0 || last_k == K_IN) begin
                        r = R_NONE; r_d = '0;
                        if (resp_q.size() > 0) begin
                            r = resp_q.pop_front();
                            r_d = resp_d_q.pop_front();
                        end
                        if (r == R_NONE) begin
                            to_pending = 1'b1;
                            to_ref = cyc;
                        end else begin
                            rx_t = int'($urandom_range(6, 2));
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input int k, input logic [3:0] e, input logic [63:0] d);
        exp_k.push_back(k); exp_e.push_back(e); exp_d.push_back(d);
    endtask

    // Next device response: scripted if a script is queued, otherwise random
    task automatic pick(input bit in_phase, input int good_pct, output int r, output logic [63:0] d);
        int x;
        d = {$urandom, $urandom};
        if (scr_q.size() > 0) begin
            r = scr_q.pop_front();
            d = scr_d_q.pop_front();
        end else begin
            x = int'($urandom_range(99, 0));
            if (!in_phase) begin
                if (x < good_pct) r = R_ACK;
                else begin
                    x = int'($urandom_range(3, 0));
                    r = (x == 0) ? R_NAK : (x == 1) ? R_ERR : (x == 2) ? R_OTHER : R_NONE;
                end
            end else begin
                if (x < good_pct) r = R_DATA;
                else r = ($urandom_range(1, 0) == 0) ? R_DERR : R_NONE;
            end
        end
    endtask

    // Transaction-level model: expected packets, device responses, result
    task automatic model(input bit wr, input logic [15:0] pg, input logic [63:0] wd, input int good_pct,
                         output bit ok, output logic [63:0] rd);
        int r, tries;
        logic [63:0] d;
        bit fin;
        exp_k.delete(); exp_e.delete(); exp_d.delete();
        resp_q.delete(); resp_d_q.delete();
        ok = 1'b0; rd = '0; fin = 1'b0;
        for (int ph = 0; ph < (wr ? 2 : 1); ph++) begin
            if (fin) break;
            tries = 0;
            forever begin
                push_exp(K_OUT, (ph == 0) ? 4'd4 : 4'd8, '0);
                push_exp(K_D0, 4'd0, (ph == 0) ? {pg, 48'h0} : wd);
                pick(1'b0, good_pct, r, d);
                resp_q.push_back(r); resp_d_q.push_back(d);
                if (r == R_ACK) break;
                tries++;
                if (tries == int'(MR)) begin fin = 1'b1; break; end
            end
        end
        if (!fin && wr) ok = 1'b1;
        if (!fin && !wr) begin
            tries = 0;
            forever begin
                push_exp(K_IN, 4'd8, '0);
                pick(1'b1, good_pct, r, d);
                resp_q.push_back(r); resp_d_q.push_back(d);
                if (r == R_DATA) begin
                    push_exp(K_ACK, 4'd0, '0);
                    ok = 1'b1; rd = d;
                    break;
                end
                if (r == R_DERR) push_exp(K_NAK, 4'd0, '0);
                tries++;
                if (tries == int'(MR)) break;
            end
        end
    endtask

    task automatic clear_log();
        log_k.delete(); log_e.delete(); log_d.delete();
        to_pending = 1'b0; viol = 0;
    endtask

    task automatic run_txn(input string name, input bit wr, input logic [15:0] pg,
                           input logic [63:0] wd, input int good_pct);
        bit ok, seen;
        logic [63:0] rd;
        int n;
        model(wr, pg, wd, good_pct, ok, rd);
        clear_log();
        @(negedge clock);
        mempage = pg; wr_data = wd; start_write = wr; start_read = !wr;
        @(negedge clock);
        start_write = 1'b0; start_read = 1'b0;
        mempage = 16'($urandom); wr_data = {$urandom, $urandom};
        chk({name, ".busy"}, 64'(busy), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            // A start while busy must be ignored
            start_read = (i == 4); start_write = (i == 4);
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        start_read = 1'b0; start_write = 1'b0;
        chk({name, ".done_seen"}, 64'(seen), 64'd1);
        chk({name, ".busy_at_done"}, 64'(busy), 64'd0);
        chk({name, ".success"}, 64'(success), 64'(ok));
        if (ok && !wr) chk({name, ".rd_data"}, rd_data, rd);
        chk({name, ".npkt"}, 64'(log_k.size()), 64'(exp_k.size()));
        n = (log_k.size() < exp_k.size()) ? log_k.size() : exp_k.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.kind%0d", name, i), 64'(log_k[i]), 64'(exp_k[i]));
            if (exp_k[i] == K_OUT || exp_k[i] == K_IN)
                chk($sformatf("%s.endp%0d", name, i), 64'(log_e[i]), 64'(exp_e[i]));
            if (exp_k[i] == K_D0)
                chk($sformatf("%s.data%0d", name, i), log_d[i], exp_d[i]);
        end
        chk({name, ".protocol"}, 64'(viol), 64'd0);
        @(negedge clock);
        chk({name, ".done_1cyc"}, 64'(done), 64'd0);
        chk({name, ".success_hold"}, 64'(success), 64'(ok));
    endtask

    task automatic chk_idle(input string name);
        chk({name, ".sends"}, 64'({send_OUT, send_IN, send_DATA0, send_ACK, send_NAK}), 64'd0);
        chk({name, ".flags"}, 64'({busy, done, success}), 64'd0);
        chk({name, ".rd_data"}, rd_data, 64'd0);
        chk({name, ".endp"}, 64'(endp), 64'd0);
        chk({name, ".data"}, data, 64'd0);
    endtask

    task automatic script(input int r, input logic [63:0] d);
        scr_q.push_back(r); scr_d_q.push_back(d);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok, reached;
        logic [63:0] rd;
        repeat (3) @(negedge clock);
        chk_idle("reset");
        reset_n = 1'b1;

        run_txn("wr_happy", 1'b1, 16'h1234, 64'h40aa11b7682df6d8, 100);

        script(R_ACK, '0); script(R_DATA, 64'h0f21000000000000);
        run_txn("rd_happy", 1'b0, 16'h0005, 64'h0, 100);

        script(R_NAK, '0); script(R_NAK, '0); script(R_ACK, '0); script(R_ACK, '0);
        run_txn("nak_retry", 1'b1, 16'hc0de, 64'h1122334455667788, 100);

        script(R_ACK, '0);
        for (int i = 0; i < 8; i++) script(R_NONE, '0);
        run_txn("rd_timeout", 1'b0, 16'h00a5, 64'h0, 100);

        script(R_ACK, '0); script(R_DERR, 64'hdeadbeefdeadbeef); script(R_DATA, 64'h5a5a00ff12345678);
        run_txn("rd_corrupt", 1'b0, 16'h7777, 64'h0, 100);

        script(R_ERR, '0); script(R_OTHER, '0); script(R_ACK, '0);
        script(R_NONE, '0); script(R_ACK, '0);
        run_txn("wr_mixed", 1'b1, 16'h0f0f, 64'hfedcba9876543210, 100);

        for (int i = 0; i < 8; i++) script(R_NAK, '0);
        run_txn("addr_abort", 1'b1, 16'h4242, 64'h0123456789abcdef, 100);

        // Reset while the data-phase DATA0 is outstanding
        model(1'b1, 16'hbeef, 64'hcafef00d0badc0de, 100, ok, rd);
        clear_log();
        @(negedge clock);
        mempage = 16'hbeef; wr_data = 64'hcafef00d0badc0de; start_write = 1'b1;
        @(negedge clock);
        start_write = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            if (log_k.size() >= 4) reached = 1'b1;
            else @(negedge clock);
        end
        chk("rst_mid.reach_xfer_data", 64'(reached), 64'd1);
        #2 reset_n = 1'b0;
        #1 chk_idle("rst_mid.async");
        @(negedge clock);
        chk_idle("rst_mid.next");
        @(negedge clock);
        reset_n = 1'b1;
        run_txn("after_rst", 1'b1, 16'h1234, 64'h40aa11b7682df6d8, 100);

        for (int i = 0; i < 30; i++) begin
            run_txn($sformatf("rand%0d", i), 1'($urandom_range(1, 0)), 16'($urandom),
                    {$urandom, $urandom}, int'($urandom_range(85, 25)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
